// File: rtl/ps2_key_event_decoder_if.sv
// rtl/ps2_key_event_decoder_if.sv - key event read port between decoder and consumer
//   ev_valid   : head event present (FIFO non-empty)
//   ev_ready   : consumer accepts the head event
//   ev_code    : head event scancode without prefix
//   ev_ext     : head event carried the E0 prefix
//   ev_release : head event is a break (F0)
//   ev_count   : FIFO occupancy, 0..FIFO_DEPTH
interface ps2_key_event_decoder_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          ev_valid;
    logic          ev_ready;
    logic [7:0]    ev_code;
    logic          ev_ext;
    logic          ev_release;
    logic [CW-1:0] ev_count;

    modport master (
        output ev_valid, ev_code, ev_ext, ev_release, ev_count,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_code, ev_ext, ev_release, ev_count,
        output ev_ready
    );
endinterface

// File: rtl/ps2_key_event_decoder.sv
// rtl/ps2_key_event_decoder.sv - PS/2 Set-2 byte stream to buffered key events
//   clk, rstn   : system clock, asynchronous active-low reset
//   scancode    : byte from the PS/2 receiver (stable while keyPressed is settling)
//   keyPressed  : PS2Clk-domain strobe, one rising edge per byte
//   ev          : event read port (master side of ps2_key_event_decoder_if)
//   overflow    : sticky, an event was dropped because the FIFO was full
//   proto_err   : one-cycle pulse on a prefix violation or prefix timeout
module ps2_key_event_decoder #(
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT_CYC     = 2000000,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [7:0]                     scancode,
    input  logic                           keyPressed,
    ps2_key_event_decoder_if.master        ev,
    output logic                           overflow,
    output logic                           proto_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

    logic [2:0]    ks;
    logic [1:0]    primed;
    logic          armed;
    logic          byte_stb;
    logic [7:0]    byte_q;
    logic          byte_v;
    state_t        state, nxt_state;
    logic [TW-1:0] tcnt;
    logic          emit, emit_rel, emit_ext, perr;
    logic          held_v, same_held, push, pop, full, do_push;
    logic [8:0]    held;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [9:0]    head;

    // Sync flops reset to 0, so a keyPressed level still high at reset
    // release would look like a rising edge. The detector only arms once
    // ks[1] holds a genuine sample of a low keyPressed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ks     <= '0;
            primed <= '0;
            armed  <= 1'b0;
        end else begin
            ks     <= {ks[1:0], keyPressed};
            primed <= {primed[0], 1'b1};
            if (primed[1] && !ks[1])
                armed <= 1'b1;
        end
    end

    assign byte_stb = armed & ks[1] & ~ks[2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_q <= '0;
            byte_v <= 1'b0;
        end else begin
            byte_v <= byte_stb;
            if (byte_stb)
                byte_q <= scancode;
        end
    end

    always_comb begin
        nxt_state = state;
        emit      = 1'b0;
        emit_rel  = 1'b0;
        emit_ext  = 1'b0;
        perr      = 1'b0;
        if (byte_v) begin
            if (byte_q == 8'h00 || byte_q == 8'hFF) begin
                nxt_state = S_IDLE;
                perr      = (state != S_IDLE);
            end else begin
                case (state)
                    S_IDLE: begin
                        if (byte_q == 8'hE0)      nxt_state = S_E0;
                        else if (byte_q == 8'hF0) nxt_state = S_F0;
                        else                      emit = 1'b1;
                    end
                    S_E0: begin
                        if (byte_q == 8'hF0)      nxt_state = S_E0F0;
                        else if (byte_q != 8'hE0) begin
                            emit      = 1'b1;
                            emit_ext  = 1'b1;
                            nxt_state = S_IDLE;
                        end
                    end
                    S_F0, S_E0F0: begin
                        nxt_state = S_IDLE;
                        if (byte_q == 8'hE0 || byte_q == 8'hF0) begin
                            perr = 1'b1;
                        end else begin
                            emit     = 1'b1;
                            emit_rel = 1'b1;
                            emit_ext = (state == S_E0F0);
                        end
                    end
                    default: nxt_state = S_IDLE;
                endcase
            end
        end else if (state != S_IDLE && tcnt == TO_LAST) begin
            nxt_state = S_IDLE;
            perr      = 1'b1;
        end
    end

    assign same_held = held_v && (held == {emit_ext, byte_q});
    assign push      = emit && !((SUPPRESS_REPEAT != 0) && !emit_rel && same_held);
    assign pop       = ev.ev_valid && ev.ev_ready;
    assign full      = (count == FULL_CNT);
    assign do_push   = push && (!full || pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            proto_err <= 1'b0;
            held      <= '0;
            held_v    <= 1'b0;
        end else begin
            state     <= nxt_state;
            proto_err <= perr;
            // Counter saturates at TO_LAST; the next byte always clears it.
            if (byte_stb)
                tcnt <= '0;
            else if (state != S_IDLE && tcnt != TO_LAST)
                tcnt <= tcnt + TW'(1);
            if (emit && SUPPRESS_REPEAT != 0) begin
                if (!emit_rel) begin
                    held   <= {emit_ext, byte_q};
                    held_v <= 1'b1;
                end else if (same_held) begin
                    held_v <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= {emit_rel, emit_ext, byte_q};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    // Memory is not reset, so the head is masked while the FIFO is empty.
    assign head          = mem[rd_ptr];
    assign ev.ev_valid   = (count != '0);
    assign ev.ev_count   = count;
    assign ev.ev_code    = ev.ev_valid ? head[7:0] : 8'h00;
    assign ev.ev_ext     = ev.ev_valid & head[8];
    assign ev.ev_release = ev.ev_valid & head[9];
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// tb/tb_ps2_key_event_decoder.sv - scoreboard bench for ps2_key_event_decoder
module tb_ps2_key_event_decoder;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] scancode = 8'h00;
    logic       keyPressed = 1'b0;
    logic       ovf_a, perr_a, ovf_b, perr_b;

    ps2_key_event_decoder_if #(.FIFO_DEPTH(4)) a_if();
    ps2_key_event_decoder_if #(.FIFO_DEPTH(4)) b_if();

    ps2_key_event_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYC(40), .SUPPRESS_REPEAT(1)) dut_a (
        .clk(clk), .rstn(rstn), .scancode(scancode), .keyPressed(keyPressed),
        .ev(a_if), .overflow(ovf_a), .proto_err(perr_a)
    );

    ps2_key_event_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYC(40), .SUPPRESS_REPEAT(0)) dut_b (
        .clk(clk), .rstn(rstn), .scancode(scancode), .keyPressed(keyPressed),
        .ev(b_if), .overflow(ovf_b), .proto_err(perr_b)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         a_pops = 0;
    int         b_pops = 0;
    int         perr_cnt = 0;
    logic [9:0] sb[$];

    // Scoreboard monitor: every accepted head event must match the oldest expectation.
    always @(negedge clk) begin
        logic [9:0] got, exp;
        if (perr_a)
            perr_cnt++;
        if (b_if.ev_valid && b_if.ev_ready)
            b_pops++;
        if (rstn && a_if.ev_valid && a_if.ev_ready) begin
            a_pops++;
            total++;
            got = {a_if.ev_release, a_if.ev_ext, a_if.ev_code};
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got=%h expected=none", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    bad++;
                    $display("FAIL sb_event got=%h expected=%h", got, exp);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        scancode   = b;
        keyPressed = 1'b1;
        repeat (8) @(posedge clk);
        #1 keyPressed = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        a_if.ev_ready = 1'b1;
        b_if.ev_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (a_if.ev_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b expected=0", a_if.ev_valid); end
        total++; if (a_if.ev_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d expected=0", a_if.ev_count); end
        total++; if (a_if.ev_code !== 8'h00) begin bad++; $display("FAIL rst_code got=%h expected=00", a_if.ev_code); end
        total++; if (a_if.ev_ext !== 1'b0) begin bad++; $display("FAIL rst_ext got=%b expected=0", a_if.ev_ext); end
        total++; if (a_if.ev_release !== 1'b0) begin bad++; $display("FAIL rst_release got=%b expected=0", a_if.ev_release); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b expected=0", ovf_a); end
        total++; if (perr_a !== 1'b0) begin bad++; $display("FAIL rst_proto_err got=%b expected=0", perr_a); end
    endtask

    task automatic test_basic;
        int p0 = perr_cnt;
        sb.push_back({1'b0, 1'b0, 8'h1C});
        send(8'h1C);
        sb.push_back({1'b1, 1'b0, 8'h1C});
        send(8'hF0);
        send(8'h1C);
        repeat (4) @(negedge clk);
        #1;
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL basic_drain got=%0d expected=0", sb.size()); end
        total++; if (perr_cnt - p0 !== 0) begin bad++; $display("FAIL basic_proto_err got=%0d expected=0", perr_cnt - p0); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL basic_overflow got=%b expected=0", ovf_a); end
    endtask

    task automatic test_ext;
        int p0 = perr_cnt;
        int lat = 0;
        sb.push_back({1'b0, 1'b1, 8'h75});
        send(8'hE0);
        @(posedge clk); #1;
        scancode   = 8'h75;
        keyPressed = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (a_if.ev_valid) begin
                lat = i;
                break;
            end
        end
        total++; if (lat < 1 || lat > 6) begin bad++; $display("FAIL ext_latency got=%0d expected=1..6", lat); end
        repeat (8) @(posedge clk);
        #1 keyPressed = 1'b0;
        repeat (8) @(posedge clk);
        sb.push_back({1'b1, 1'b1, 8'h75});
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        repeat (4) @(negedge clk);
        #1;
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL ext_drain got=%0d expected=0", sb.size()); end
        total++; if (perr_cnt - p0 !== 0) begin bad++; $display("FAIL ext_proto_err got=%0d expected=0", perr_cnt - p0); end
    endtask

    task automatic test_repeat;
        int a0 = a_pops;
        int b0 = b_pops;
        sb.push_back({1'b0, 1'b0, 8'h1C});
        sb.push_back({1'b1, 1'b0, 8'h1C});
        send(8'h1C);
        send(8'h1C);
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        repeat (4) @(negedge clk);
        #1;
        total++; if (a_pops - a0 !== 2) begin bad++; $display("FAIL repeat_suppressed got=%0d expected=2", a_pops - a0); end
        total++; if (b_pops - b0 !== 4) begin bad++; $display("FAIL repeat_passed got=%0d expected=4", b_pops - b0); end
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL repeat_drain got=%0d expected=0", sb.size()); end
    endtask

    task automatic test_overflow;
        int a0;
        @(posedge clk); #1 a_if.ev_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            send(8'h10 + 8'(i));
        @(negedge clk);
        total++; if (a_if.ev_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d expected=4", a_if.ev_count); end
        total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b expected=1", ovf_a); end
        total++; if (a_if.ev_code !== 8'h10) begin bad++; $display("FAIL ovf_head got=%h expected=10", a_if.ev_code); end
        for (int i = 0; i < 4; i++)
            sb.push_back({2'b00, 8'h10 + 8'(i)});
        a0 = a_pops;
        @(posedge clk); #1 a_if.ev_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (!a_if.ev_valid) break;
        end
        total++; if (a_pops - a0 !== 4) begin bad++; $display("FAIL ovf_pops got=%0d expected=4", a_pops - a0); end
        total++; if (a_if.ev_valid !== 1'b0) begin bad++; $display("FAIL ovf_valid_fall got=%b expected=0", a_if.ev_valid); end
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL ovf_drain got=%0d expected=0", sb.size()); end
        total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b expected=1", ovf_a); end
    endtask

    task automatic test_timeout;
        int p0 = perr_cnt;
        send(8'hF0);
        repeat (60) @(posedge clk);
        #1;
        total++; if (perr_cnt - p0 !== 1) begin bad++; $display("FAIL timeout_pulse got=%0d expected=1", perr_cnt - p0); end
        sb.push_back({1'b0, 1'b0, 8'h1C});
        send(8'h1C);
        repeat (4) @(negedge clk);
        #1;
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL timeout_next_make got=%0d expected=0", sb.size()); end
        total++; if (perr_cnt - p0 !== 1) begin bad++; $display("FAIL timeout_no_extra got=%0d expected=1", perr_cnt - p0); end
    endtask

    task automatic test_midreset;
        int p0;
        send(8'hE0);
        @(posedge clk); #1;
        scancode   = 8'h75;
        keyPressed = 1'b1;
        @(posedge clk); #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        p0 = perr_cnt;
        repeat (8) @(posedge clk);
        #1 keyPressed = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        total++; if (a_if.ev_count !== 3'd0) begin bad++; $display("FAIL mrst_count got=%0d expected=0", a_if.ev_count); end
        total++; if (a_if.ev_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%b expected=0", a_if.ev_valid); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL mrst_overflow got=%b expected=0", ovf_a); end
        total++; if (perr_cnt - p0 !== 0) begin bad++; $display("FAIL mrst_proto_err got=%0d expected=0", perr_cnt - p0); end
        sb.push_back({1'b0, 1'b0, 8'h75});
        send(8'h75);
        repeat (4) @(negedge clk);
        #1;
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL mrst_make got=%0d expected=0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ext();
        test_repeat();
        test_overflow();
        test_timeout();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end
endmodule

// File: doc/ps2_key_event_decoder.md
Name: ps2_key_event_decoder

Overview:
- Sits between the PS/2 receiver (PS2Clk domain: scancode[7:0], keyPressed) and the colour constructor (clk domain).
- Synchronises the receiver's byte strobe into clk and decodes Set-2 prefixes (E0 extended, F0 break) into whole key events.
- Optionally suppresses typematic repeats.
- Buffers events in a small FIFO with a valid/ready read port for the colour constructor.

Parameters:
- FIFO_DEPTH, 4: event FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYC, 2000000: clk cycles a prefix state may wait for its next byte before abandoning (20 ms at 100 MHz).
- SUPPRESS_REPEAT, 1: 1 = drop a make identical to the held key; 0 = pass every make.

Ports:
- clk, input, 1: system clock.
- rstn, input, 1: asynchronous active-low reset.
- scancode, input, 8: byte from the PS/2 receiver; stable ≥4 clk cycles after keyPressed rises.
- keyPressed, input, 1: PS2Clk-domain strobe; rises once per received byte.
- ev_ready, input, 1: consumer accepts the head event.
- ev_valid, output, 1: FIFO non-empty.
- ev_code, output, 8: head event scancode, without prefix.
- ev_ext, output, 1: head event had the E0 prefix.
- ev_release, output, 1: head event is a break (F0).
- ev_count, output, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- overflow, output, 1: sticky; an event was dropped because the FIFO was full.
- proto_err, output, 1: one-cycle pulse on a prefix violation or timeout.

Behaviour:
- Reset (async, rstn=0): sync flops 0; FSM IDLE; FIFO empty; held-key valid 0; timeout counter 0. Outputs: ev_valid=0, ev_code=0, ev_ext=0, ev_release=0, ev_count=0, overflow=0, proto_err=0.
- CDC: keyPressed passes through a 2-flop synchroniser, then a third flop for rising-edge detect.
- byte_stb is a one-cycle pulse on the synchronised rising edge. scancode is registered into byte_q on byte_stb, and the FSM acts on byte_q the following cycle.
- Byte 0x00 or 0xFF (receiver error/overrun) in any state: discard, FSM→IDLE, proto_err pulses only if the state was not IDLE.
- FSM transitions:
  - IDLE: E0→E0; F0→F0; other→emit {rel=0, ext=0, code}, stay IDLE.
  - E0: F0→E0F0; E0→stay E0 (restart timer); other→emit {0,1,code}, →IDLE.
  - F0: E0 or F0→proto_err, →IDLE; other→emit {1,0,code}, →IDLE.
  - E0F0: E0 or F0→proto_err, →IDLE; other→emit {1,1,code}, →IDLE.
- Timeout: counter clears on every byte_stb and increments while in a non-IDLE state. When it reaches TIMEOUT_CYC-1, the FSM goes to IDLE and proto_err pulses. The counter saturates and does not wrap.
- Repeat suppression (SUPPRESS_REPEAT=1):
  - The held register {ext, code} plus a held-valid bit tracks the current key.
  - A make equal to the held key while held-valid=1 is dropped; it is not an overflow.
  - Any other make loads held and sets held-valid.
  - A break matching held clears held-valid.
  - A break not matching held is still emitted and leaves held unchanged.
- Emit latency: event written to the FIFO 2 clk cycles after byte_stb, i.e. at most 6 clk cycles after keyPressed rises.
- FIFO:
  - First-word fall-through; outputs driven directly from the head entry; entry = {release, ext, code}.
  - Pop when ev_valid && ev_ready. ev_ready while empty has no effect.
  - Push while full without a same-cycle pop: event dropped, overflow set. overflow clears only on reset.
  - Push while full with a same-cycle pop: both occur, count unchanged.
  - Push while empty: ev_valid rises the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; ev_count ranges 0..FIFO_DEPTH.
- Mid-frame reset: all state cleared immediately. A keyPressed level still high at reset release must not produce a byte_stb, so the sync flops are not preset to 1.

Test Plan:
- Reset then bytes 1C; F0,1C with ev_ready=1 → events {0,0,0x1C} then {1,0,0x1C}; no proto_err; overflow=0.
- Bytes E0,75; E0,F0,75 → events {0,1,0x75} then {1,1,0x75}. The first event appears ≤6 cycles after the second keyPressed edge.
- SUPPRESS_REPEAT=1, bytes 1C,1C,1C,F0,1C → exactly 2 events, make then break. With SUPPRESS_REPEAT=0 → 4 events.
- ev_ready=0, FIFO_DEPTH=4, six makes of distinct codes → ev_count=4 and overflow=1 holding the first four codes in order. Then ev_ready=1 → pops in order, ev_valid falls after the 4th pop.
- Byte F0 followed by TIMEOUT_CYC idle cycles → one proto_err pulse, FSM in IDLE. Next byte 1C → make {0,0,0x1C}, not a break.
- Assert rstn=0 between E0 and 75, release, send 75 → make {0,0,0x75}, no stale ext, FIFO empty before it.
